// File: rtl/pe_array_bd_pkg.sv
// pe_array_bd_pkg: shared parameters, derived widths and result reduction (SATURATE_EN selects saturate vs wrap)
package pe_array_bd_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int NUM_PE = 8;
    localparam int VEC_LEN = 32;
    localparam int CW = 2 * DATA_WIDTH;
    localparam int PE_W = $clog2(NUM_PE);
    localparam int IDX_W = $clog2(VEC_LEN);
    localparam int WORD_W = IDX_W + 1;
    localparam int FRAME_LEN = 2 * VEC_LEN * NUM_PE;
    localparam logic [PE_W-1:0] PE_LAST = PE_W'(NUM_PE - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(2 * VEC_LEN - 1);
    localparam logic signed [CW:0] SAT_HI = (CW + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [CW:0] SAT_LO = -SAT_HI - 1;

    function automatic logic [DATA_WIDTH-1:0] reduce(input logic signed [CW:0] s);
        logic signed [CW:0] t;
        t = s >>> (DATA_WIDTH - 1);
`ifdef SATURATE_EN
        return (t > SAT_HI) ? SAT_HI[DATA_WIDTH-1:0] : (t < SAT_LO) ? SAT_LO[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0];
`else
        return t[DATA_WIDTH-1:0];
`endif
    endfunction
endpackage

// File: rtl/pe_array_bd_pe_unit.sv
// pe_array_bd_pe_unit: one PE -- A register file plus 3-stage complex multiplier with valid pipeline
module pe_array_bd_pe_unit
    import pe_array_bd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             a_we,
    input  logic             b_v,
    input  logic [IDX_W-1:0] addr,
    input  logic [CW-1:0]    din,
    output logic             y_v,
    output logic [CW-1:0]    y
);
    logic [CW-1:0] a_mem [VEC_LEN];
    logic [CW-1:0] a_q, b_q, r_q;
    logic v1, v2, v3;
    logic signed [CW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [DATA_WIDTH-1:0] ar, ai, br, bi;

    assign ar = a_q[CW-1:DATA_WIDTH];
    assign ai = a_q[DATA_WIDTH-1:0];
    assign br = b_q[CW-1:DATA_WIDTH];
    assign bi = b_q[DATA_WIDTH-1:0];
    assign y_v = v3;
    assign y = v3 ? r_q : '0;

    // A vector storage, written during this PE's A phase
    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < VEC_LEN; i++) a_mem[i] <= '0;
        else if (a_we)
            a_mem[addr] <= din;
    end

    // input register -> partial products -> add, shift and reduce
    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3} <= '0;
            {a_q, b_q, r_q} <= '0;
            {p_rr, p_ii, p_ri, p_ir} <= '0;
        end else begin
            v1 <= b_v;
            v2 <= v1;
            v3 <= v2;
            a_q <= a_mem[addr];
            b_q <= din;
            p_rr <= CW'(ar) * CW'(br);
            p_ii <= CW'(ai) * CW'(bi);
            p_ri <= CW'(ar) * CW'(bi);
            p_ir <= CW'(ai) * CW'(br);
            r_q <= {reduce((CW + 1)'(p_rr) - (CW + 1)'(p_ii)), reduce((CW + 1)'(p_ri) + (CW + 1)'(p_ir))};
        end
    end
endmodule

// File: rtl/pe_array_bd.sv
// pe_array_bd: streams words block-wise into NUM_PE PEs and returns their products serially (SATURATE_EN: saturating results)
module pe_array_bd
    import pe_array_bd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          din_v,
    input  logic [CW-1:0] din,
    output logic          dout_v,
    output logic [CW-1:0] dout
);
    logic [PE_W-1:0] pe_idx, cur_pe;
    logic [WORD_W-1:0] word_idx, cur_word;
    logic [NUM_PE-1:0] a_we, b_v, y_v;
    logic [CW-1:0] y [NUM_PE];
    logic [CW-1:0] y_or;
    logic v_or;

    assign cur_pe = load ? '0 : pe_idx;
    assign cur_word = load ? '0 : word_idx;

    // distribution pointer; load restarts it so a word accepted with load lands at PE0 A[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_idx <= '0;
            word_idx <= '0;
        end else begin
            word_idx <= din_v ? ((cur_word == WORD_LAST) ? '0 : cur_word + 1'b1) : cur_word;
            pe_idx <= (din_v && cur_word == WORD_LAST) ? ((cur_pe == PE_LAST) ? '0 : cur_pe + 1'b1) : cur_pe;
        end
    end

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        assign a_we[p] = din_v && cur_pe == PE_W'(p) && !cur_word[WORD_W-1];
        assign b_v[p] = din_v && cur_pe == PE_W'(p) && cur_word[WORD_W-1];
        pe_array_bd_pe_unit u_pe (
            .clk (clk),
            .rst (rst),
            .a_we(a_we[p]),
            .b_v (b_v[p]),
            .addr(cur_word[IDX_W-1:0]),
            .din (din),
            .y_v (y_v[p]),
            .y   (y[p])
        );
    end

    // PE outputs are already gated by their valids, so a plain OR merges them
    always_comb begin
        y_or = '0;
        v_or = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            y_or = y_or | y[i];
            v_or = v_or | y_v[i];
        end
    end

    // registered output port
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_v <= 1'b0;
            dout <= '0;
        end else begin
            dout_v <= v_or;
            dout <= y_or;
        end
    end
endmodule

// File: tb/tb_pe_array_bd.sv
// tb_pe_array_bd: randomized stream against a behavioural model of the PE array
module tb_pe_array_bd;
    logic clk = 0, rst = 1, load = 0, din_v = 0;
    logic [31:0] din = 0;
    logic dout_v;
    logic [31:0] dout;

    typedef struct {int due; logic [31:0] d;} exp_t;
    exp_t q[$];
    logic [31:0] a_ref [8][32];
    int cyc = 0, pos = 0, out_cnt = 0;
    int n_cmp = 0, n_err = 0;

    pe_array_bd dut (.clk(clk), .rst(rst), .load(load), .din_v(din_v), .din(din), .dout_v(dout_v), .dout(dout));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] fit(input longint v);
`ifdef SATURATE_EN
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    function automatic logic [31:0] cmul(input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        return {fit((ar * br - ai * bi) >>> 15), fit((ar * bi + ai * br) >>> 15)};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pos = 0;
            foreach (a_ref[p, i]) a_ref[p][i] = 0;
            q.delete();
        end else begin
            if (load) pos = 0;
            if (din_v) begin
                if (pos % 64 < 32) a_ref[pos / 64][pos % 64] = din;
                else q.push_back('{cyc + 3, cmul(a_ref[pos / 64][pos % 64 - 32], din)});
                pos = (pos + 1) % 512;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            bit ev;
            ev = q.size() > 0 && q[0].due == cyc;
            check("dout_v", 32'(dout_v), 32'(ev));
            if (ev) begin
                check("dout", dout, q[0].d);
                void'(q.pop_front());
            end else check("dout_idle", dout, 0);
            if (dout_v) out_cnt++;
        end
    end

    task automatic drive(input bit v, input bit ld, input logic [31:0] d);
        din_v = v;
        load = ld;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [31:0] d, input bit ld, input int gap_pct);
        if (int'($urandom_range(99)) < gap_pct) drive(0, 0, $urandom);
        drive(1, ld, d);
    endtask

    task automatic pe_block(input logic [31:0] a, input logic [31:0] b, input bit ld, input int gap_pct);
        for (int i = 0; i < 64; i++) word(i < 32 ? a : b, ld && i == 0, gap_pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, $urandom);
    endtask

    initial begin
        int c0;
        rst = 1;
        din_v = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive(1, 0, $urandom);
        rst = 0;
        idle(2);
        for (int p = 0; p < 8; p++) pe_block(32'h4000_0000, 32'h4000_0000, 0, 0);
        idle(5);
        pe_block(32'h4000_4000, 32'h4000_C000, 1, 20);
        pe_block(32'h8000_0000, 32'h8000_0000, 0, 20);
        idle(5);
        c0 = out_cnt;
        for (int i = 0; i < 1024; i++) word($urandom, i == 0, 30);
        idle(6);
        check("count1024", 32'(out_cnt - c0), 512);
        for (int i = 0; i < 3 * 64 + 10; i++) word($urandom, i == 0, 20);
        for (int i = 0; i < 600; i++) word($urandom, i == 0, 20);
        for (int i = 0; i < 64 + 40; i++) word($urandom, i == 0, 0);
        for (int i = 0; i < 200; i++) word($urandom, i == 0, 10);
        idle(6);
        check("drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
